// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM core front end.
package arm_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot in the same edge, so push-at-full is fine alongside it.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues imem reads and buffers words for the core.
module fetch_queue
    import arm_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_OUT+1);
    localparam int FW = $clog2(DEPTH+1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] live;
    logic [FW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          can_issue;
    logic          grant;
    logic          push;
    logic          pop;
    logic          drop_rsp;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // Words still owed to the FIFO count against its space so a push never overflows it.
    assign live      = inflight - drop_cnt;
    assign can_issue = ((32'(fifo_count) + 32'(live)) < 32'(DEPTH)) &&
                       (32'(inflight) < 32'(MAX_OUT));
    assign mem_req   = can_issue & ~redirect & ~reset;
    assign mem_addr  = fetch_pc;
    assign grant     = mem_req & mem_gnt;

    assign drop_rsp   = mem_rvalid & (drop_cnt != '0);
    assign push       = mem_rvalid & (drop_cnt == '0) & ~redirect;
    assign pop        = instr_valid & instr_ready & ~redirect;
    assign push_entry = '{pc: resp_pc, instr: mem_rdata};

    assign instr_valid = ~fifo_empty;
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // On redirect every outstanding request, including one answering this cycle, becomes stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            inflight <= inflight - CW'(mem_rvalid);
            drop_cnt <= inflight - CW'(mem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + PC_INC;
            if (push)  resp_pc  <= resp_pc + PC_INC;
            if (drop_rsp) drop_cnt <= drop_cnt - CW'(1);
            inflight <= inflight + CW'(grant) - CW'(mem_rvalid);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                    !(push && fifo_full && !pop));

endmodule
